// File: rtl/avalon_timer_driver.sv
// -----------------------------------------------------------------------------
// avalon_timer_driver
//   Avalon-MM master that programs and services a 16-bit-data interval-timer
//   slave (s1 register map) without a processor. A command port accepts
//   START / STOP / SNAP / CLRCNT. Timer interrupts are acknowledged on the bus
//   and presented to user logic as a one-cycle tick plus a running count.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; accepted when both are high at an
//                       edge and tmr_irq is low (a pending IRQ wins)
//   cmd_op              00 START, 01 STOP, 10 SNAP, 11 CLRCNT
//   cmd_period          timer period for START
//   cmd_cont, cmd_ien   continuous mode / interrupt enable for START
//   rsp_valid/rsp_data  one-cycle completion pulse and its data
//   tick, tick_count    one pulse per serviced timeout / wrapping count
//   tmr_*               Avalon-MM master to the timer slave (no waitrequest)
//   tmr_irq             timer interrupt, level
//
// Build option
//   TMR_DRV_AUTOSTOP_EN : when defined, the IRQ service that brings tick_count
//   to TICK_LIMIT issues a STOP control write by itself and reports it with
//   rsp_data = 32'hFFFF_FFFF. Undefined: no limit check, TICK_LIMIT unused.
// -----------------------------------------------------------------------------
module avalon_timer_driver #(
   parameter int unsigned TICK_W     = 16,
   parameter int unsigned TICK_LIMIT = 1000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [31:0]       cmd_period,
   input  logic              cmd_cont,
   input  logic              cmd_ien,
   output logic              rsp_valid,
   output logic [31:0]       rsp_data,
   output logic              tick,
   output logic [TICK_W-1:0] tick_count,
   output logic [2:0]        tmr_address,
   output logic              tmr_chipselect,
   output logic              tmr_write_n,
   output logic [15:0]       tmr_writedata,
   input  logic [15:0]       tmr_readdata,
   input  logic              tmr_irq
);

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned RSP_W  = 32;
   localparam int unsigned BUS_W  = 2 + ADDR_W + DATA_W;

   // Slave word addresses
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_PER_L  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_PER_H  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_SNAP_L = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_SNAP_H = ADDR_W'(5);

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_STOP   = 2'b01;
   localparam logic [1:0] OP_SNAP   = 2'b10;
   localparam logic [1:0] OP_CLRCNT = 2'b11;

   // Bus word layout: {chipselect, write_n, address, writedata}
   localparam logic [BUS_W-1:0] BUS_IDLE = {1'b0, 1'b1, ADDR_W'(0), DATA_W'(0)};

   typedef enum logic [3:0] {
      IDLE, ST_PL, ST_PH, ST_GAP, ST_CTL, SP_CTL,
      SN_WR, SN_RL, SN_RH, SN_CAP, ACK, ACK_GAP, RSP
   } state_t;

   function automatic logic [BUS_W-1:0] bus_wr(input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] d);
      return {1'b1, 1'b0, a, d};
   endfunction

   function automatic logic [BUS_W-1:0] bus_rd(input logic [ADDR_W-1:0] a);
      return {1'b1, 1'b1, a, DATA_W'(0)};
   endfunction

   // Control register value: bit3 STOP, bit2 START, bit1 CONT, bit0 ITO
   function automatic logic [DATA_W-1:0] ctl_word(input logic stop, input logic start,
                                                 input logic cont, input logic ien);
      return {(DATA_W-4)'(0), stop, start, cont, ien};
   endfunction

   state_t              state, state_d;
   logic [BUS_W-1:0]    bus_q, bus_d;
   logic                cmd_ready_d;
   logic                rsp_valid_d;
   logic [RSP_W-1:0]    rsp_data_d;
   logic                tick_d;
   logic [TICK_W-1:0]   tick_count_d;

   // Fields of the command in flight
   logic [RSP_W-1:0]    per_q, per_d;
   logic                cont_q, cont_d;
   logic                ien_q, ien_d;
   // Mode of the last completed START, reused by STOP writes
   logic                lat_cont, lat_cont_d;
   logic                lat_ien, lat_ien_d;
   logic [DATA_W-1:0]   snap_lo, snap_lo_d;
   // Marks a STOP that the driver issued on its own
   logic                auto_q, auto_d;

   assign {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} = bus_q;

`ifndef TMR_DRV_AUTOSTOP_EN
   logic [TICK_W-1:0] unused_limit;
   assign unused_limit = TICK_W'(TICK_LIMIT);
`endif

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         bus_q      <= BUS_IDLE;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         tick       <= 1'b0;
         tick_count <= '0;
         per_q      <= '0;
         cont_q     <= 1'b0;
         ien_q      <= 1'b0;
         lat_cont   <= 1'b0;
         lat_ien    <= 1'b0;
         snap_lo    <= '0;
         auto_q     <= 1'b0;
      end else begin
         state      <= state_d;
         bus_q      <= bus_d;
         cmd_ready  <= cmd_ready_d;
         rsp_valid  <= rsp_valid_d;
         rsp_data   <= rsp_data_d;
         tick       <= tick_d;
         tick_count <= tick_count_d;
         per_q      <= per_d;
         cont_q     <= cont_d;
         ien_q      <= ien_d;
         lat_cont   <= lat_cont_d;
         lat_ien    <= lat_ien_d;
         snap_lo    <= snap_lo_d;
         auto_q     <= auto_d;
      end
   end

   // Next state and next register values; outputs reflect the state entered
   always_comb begin
      state_d      = state;
      bus_d        = BUS_IDLE;
      cmd_ready_d  = 1'b0;
      rsp_valid_d  = 1'b0;
      rsp_data_d   = '0;
      tick_d       = 1'b0;
      tick_count_d = tick_count;
      per_d        = per_q;
      cont_d       = cont_q;
      ien_d        = ien_q;
      lat_cont_d   = lat_cont;
      lat_ien_d    = lat_ien;
      snap_lo_d    = snap_lo;
      auto_d       = auto_q;

      unique case (state)
         IDLE: begin
            if (tmr_irq) begin
               // A pending timeout is serviced before any command
               state_d = ACK;
               bus_d   = bus_wr(A_STATUS, DATA_W'(0));
            end else if (cmd_valid && cmd_ready) begin
               per_d  = cmd_period;
               cont_d = cmd_cont;
               ien_d  = cmd_ien;
               auto_d = 1'b0;
               unique case (cmd_op)
                  OP_START: begin
                     state_d = ST_PL;
                     bus_d   = bus_wr(A_PER_L, cmd_period[15:0]);
                  end
                  OP_STOP: begin
                     state_d = SP_CTL;
                     bus_d   = bus_wr(A_CTRL, ctl_word(1'b1, 1'b0, lat_cont, lat_ien));
                  end
                  OP_SNAP: begin
                     state_d = SN_WR;
                     bus_d   = bus_wr(A_SNAP_L, DATA_W'(0));
                  end
                  OP_CLRCNT: begin
                     state_d      = RSP;
                     tick_count_d = '0;
                     rsp_valid_d  = 1'b1;
                  end
                  default: state_d = IDLE;
               endcase
            end else begin
               cmd_ready_d = 1'b1;
            end
         end

         ST_PL: begin
            state_d = ST_PH;
            bus_d   = bus_wr(A_PER_H, per_q[31:16]);
         end

         // Idle guard cycle lets the slave finish its force-reload
         ST_PH: state_d = ST_GAP;

         ST_GAP: begin
            state_d = ST_CTL;
            bus_d   = bus_wr(A_CTRL, ctl_word(1'b0, 1'b1, cont_q, ien_q));
         end

         ST_CTL: begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = per_q;
            lat_cont_d  = cont_q;
            lat_ien_d   = ien_q;
         end

         SP_CTL: begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = auto_q ? '1 : '0;
         end

         SN_WR: begin
            state_d = SN_RL;
            bus_d   = bus_rd(A_SNAP_L);
         end

         // readdata lags the address by one cycle
         SN_RL: begin
            state_d = SN_RH;
            bus_d   = bus_rd(A_SNAP_H);
         end

         SN_RH: begin
            state_d   = SN_CAP;
            snap_lo_d = tmr_readdata;
         end

         SN_CAP: begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {tmr_readdata, snap_lo};
         end

         ACK: begin
            state_d      = ACK_GAP;
            tick_d       = 1'b1;
            tick_count_d = tick_count + TICK_W'(1);
         end

         // tmr_irq is not acted on here: the slave may still be dropping it
         ACK_GAP: begin
`ifdef TMR_DRV_AUTOSTOP_EN
            if (tick_count == TICK_W'(TICK_LIMIT)) begin
               state_d = SP_CTL;
               auto_d  = 1'b1;
               bus_d   = bus_wr(A_CTRL, ctl_word(1'b1, 1'b0, lat_cont, lat_ien));
            end else
`endif
            begin
               state_d     = IDLE;
               cmd_ready_d = !tmr_irq;
            end
         end

         RSP: begin
            state_d     = IDLE;
            auto_d      = 1'b0;
            cmd_ready_d = !tmr_irq;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_avalon_timer_driver.sv
// -----------------------------------------------------------------------------
// tb_avalon_timer_driver
//   Directed plus randomized bench for avalon_timer_driver. A reference model
//   derives, for each command, the list of bus cycles and the response from the
//   register-map rules, and tracks latched mode bits and the tick count.
//   Honors TMR_DRV_AUTOSTOP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_avalon_timer_driver;

   localparam int unsigned TICK_W = 16;
   localparam int unsigned LIMIT  = 3;

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_STOP   = 2'b01;
   localparam logic [1:0] OP_SNAP   = 2'b10;
   localparam logic [1:0] OP_CLRCNT = 2'b11;

   localparam logic [20:0] BIDLE = {1'b0, 1'b1, 3'd0, 16'h0};

   logic              clk = 1'b0;
   logic              reset_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [31:0]       cmd_period;
   logic              cmd_cont;
   logic              cmd_ien;
   logic              rsp_valid;
   logic [31:0]       rsp_data;
   logic              tick;
   logic [TICK_W-1:0] tick_count;
   logic [2:0]        tmr_address;
   logic              tmr_chipselect;
   logic              tmr_write_n;
   logic [15:0]       tmr_writedata;
   logic [15:0]       tmr_readdata;
   logic              tmr_irq;

   logic [20:0]       bus_obs;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic              m_cont;
   logic              m_ien;
   logic [TICK_W-1:0] m_ticks;
   logic [15:0]       snap_lo_val;
   logic [15:0]       snap_hi_val;

   always #5 clk = ~clk;

   avalon_timer_driver #(.TICK_W(TICK_W), .TICK_LIMIT(LIMIT)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_period     (cmd_period),
      .cmd_cont       (cmd_cont),
      .cmd_ien        (cmd_ien),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .tick           (tick),
      .tick_count     (tick_count),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .tmr_readdata   (tmr_readdata),
      .tmr_irq        (tmr_irq)
   );

   assign bus_obs = {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};

   // Slave read port: registered, returns the snapshot halves
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tmr_readdata <= 16'h0;
      else if (tmr_chipselect && tmr_write_n)
         tmr_readdata <= (tmr_address == 3'd4) ? snap_lo_val :
                         (tmr_address == 3'd5) ? snap_hi_val : 16'h0;
      else
         tmr_readdata <= 16'h0;
   end

   function automatic logic [20:0] bw(input int a, input int d);
      return {1'b1, 1'b0, 3'(a), 16'(d)};
   endfunction

   function automatic logic [20:0] br(input int a);
      return {1'b1, 1'b1, 3'(a), 16'h0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge where tmr_irq was just raised in IDLE
   task automatic service_irq();
      @(negedge clk);
      check("ack_bus", 64'(bus_obs), 64'(bw(0, 0)));
      check("ack_ready", 64'(cmd_ready), 64'd0);
      check("ack_tick", 64'(tick), 64'd0);
      tmr_irq = 1'b0;
      m_ticks = m_ticks + TICK_W'(1);
      @(negedge clk);
      check("gap_tick", 64'(tick), 64'd1);
      check("gap_count", 64'(tick_count), 64'(m_ticks));
      check("gap_bus", 64'(bus_obs), 64'(BIDLE));
      check("gap_ready", 64'(cmd_ready), 64'd0);
`ifdef TMR_DRV_AUTOSTOP_EN
      if (m_ticks == TICK_W'(LIMIT)) begin
         @(negedge clk);
         check("auto_bus", 64'(bus_obs), 64'(bw(1, 8 + 2 * int'(m_cont) + int'(m_ien))));
         check("auto_ready", 64'(cmd_ready), 64'd0);
         @(negedge clk);
         check("auto_rsp_valid", 64'(rsp_valid), 64'd1);
         check("auto_rsp_data", 64'(rsp_data), 64'hFFFF_FFFF);
         check("auto_rsp_ready", 64'(cmd_ready), 64'd0);
      end
`endif
      @(negedge clk);
      check("post_ack_bus", 64'(bus_obs), 64'(BIDLE));
      check("post_ack_tick", 64'(tick), 64'd0);
      check("post_ack_rsp", 64'(rsp_valid), 64'd0);
      check("post_ack_ready", 64'(cmd_ready), 64'd1);
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 64'(cmd_ready), 64'd1);
      check("idle_rsp", 64'(rsp_valid), 64'd0);
   endtask

   task automatic raise_irq();
      wait_ready();
      tmr_irq = 1'b1;
      service_irq();
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [31:0] per,
                         input logic c, input logic i, input bit with_irq);
      logic [20:0] exp_bus[$];
      logic [31:0] exp_rsp;
      wait_ready();
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_period = per;
      cmd_cont   = c;
      cmd_ien    = i;
      if (with_irq) begin
         tmr_irq = 1'b1;
         service_irq();
      end
      exp_bus = {};
      exp_rsp = 32'h0;
      case (op)
         OP_START: begin
            exp_bus.push_back(bw(2, int'(per[15:0])));
            exp_bus.push_back(bw(3, int'(per[31:16])));
            exp_bus.push_back(BIDLE);
            exp_bus.push_back(bw(1, 4 + 2 * int'(c) + int'(i)));
            exp_rsp = per;
         end
         OP_STOP: exp_bus.push_back(bw(1, 8 + 2 * int'(m_cont) + int'(m_ien)));
         OP_SNAP: begin
            exp_bus.push_back(bw(4, 0));
            exp_bus.push_back(br(4));
            exp_bus.push_back(br(5));
            exp_bus.push_back(BIDLE);
            exp_rsp = {snap_hi_val, snap_lo_val};
         end
         default: m_ticks = '0;
      endcase
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < exp_bus.size(); k++) begin
         check($sformatf("op%0d_bus_c%0d", op, k + 1), 64'(bus_obs), 64'(exp_bus[k]));
         check($sformatf("op%0d_rsp_c%0d", op, k + 1), 64'(rsp_valid), 64'd0);
         check($sformatf("op%0d_ready_c%0d", op, k + 1), 64'(cmd_ready), 64'd0);
         @(negedge clk);
      end
      check($sformatf("op%0d_rsp_valid", op), 64'(rsp_valid), 64'd1);
      check($sformatf("op%0d_rsp_data", op), 64'(rsp_data), 64'(exp_rsp));
      check($sformatf("op%0d_count", op), 64'(tick_count), 64'(m_ticks));
      check($sformatf("op%0d_rsp_bus", op), 64'(bus_obs), 64'(BIDLE));
      if (op == OP_START) begin
         m_cont = c;
         m_ien  = i;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op     = 2'b00;
      cmd_period = 32'h0;
      cmd_cont   = 1'b0;
      cmd_ien    = 1'b0;
      tmr_irq    = 1'b0;
      m_cont     = 1'b0;
      m_ien      = 1'b0;
      m_ticks    = '0;
      snap_lo_val = 16'h1234;
      snap_hi_val = 16'h0005;

      // Reset values while held
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(cmd_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_tick", 64'(tick), 64'd0);
      check("rst_count", 64'(tick_count), 64'd0);
      check("rst_bus", 64'(bus_obs), 64'(BIDLE));
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 64'(cmd_ready), 64'd1);

      // Directed scenarios
      do_cmd(OP_START, 32'h0001_86A0, 1'b1, 1'b1, 1'b0);
      raise_irq();
      do_cmd(OP_SNAP, 32'h0, 1'b0, 1'b0, 1'b0);
      do_cmd(OP_STOP, 32'h0, 1'b0, 1'b0, 1'b1);
      do_cmd(OP_START, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
      do_cmd(OP_STOP, 32'h0, 1'b0, 1'b0, 1'b0);

      // Tick limit: reaching it auto-stops only when the option is built in
      do_cmd(OP_CLRCNT, 32'h0, 1'b0, 1'b0, 1'b0);
      do_cmd(OP_START, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
      repeat (3) raise_irq();
      raise_irq();

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         int sel;
         sel = int'($urandom_range(0, 4));
         snap_lo_val = 16'($urandom());
         snap_hi_val = 16'($urandom());
         if (sel == 4)
            raise_irq();
         else
            do_cmd(2'(sel), $urandom(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      // Asynchronous reset in the middle of a SNAP read
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = OP_SNAP;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("mid_c1_bus", 64'(bus_obs), 64'(bw(4, 0)));
      @(negedge clk);
      check("mid_c2_bus", 64'(bus_obs), 64'(br(4)));
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_bus", 64'(bus_obs), 64'(BIDLE));
      check("mid_rst_rsp", 64'(rsp_valid), 64'd0);
      check("mid_rst_ready", 64'(cmd_ready), 64'd0);
      check("mid_rst_count", 64'(tick_count), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_cont  = 1'b0;
      m_ien   = 1'b0;
      m_ticks = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_rsp", 64'(rsp_valid), 64'd0);
         check("post_rst_bus", 64'(bus_obs), 64'(BIDLE));
      end
      // Latched mode bits were cleared by reset
      do_cmd(OP_STOP, 32'h0, 1'b1, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
